// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and bridge state type.
// Imported by the bridge, its interface and the timeout counter.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } state_t;

   function automatic logic is_legal(
      input logic [2:0] hsize,
      input logic [1:0] alo
   );
      return (hsize == HSIZE_WORD) && (alo == 2'b00);
   endfunction

endpackage

// File: rtl/ahb_slave_bridge_if.sv
// AHB-Lite subordinate bus plus the simple register port.
// slave: bridge view; master: bus driver / register model view.
interface ahb_slave_bridge_if #(
   parameter int ADDR_W = 8
);
   import ahb_pkg::*;

   logic              HSEL;
   logic [31:0]       HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [31:0]       HWDATA;
   logic              HREADY;
   logic              HREADYOUT;
   logic              HRESP;
   logic [31:0]       HRDATA;

   logic              usr_req;
   logic              usr_we;
   logic [ADDR_W-1:0] usr_addr;
   logic [31:0]       usr_wdata;
   logic              usr_ack;
   logic              usr_err;
   logic [31:0]       usr_rdata;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
      input  HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA,
      output usr_req, usr_we, usr_addr, usr_wdata,
      input  usr_ack, usr_err, usr_rdata
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
      output HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA,
      input  usr_req, usr_we, usr_addr, usr_wdata,
      output usr_ack, usr_err, usr_rdata
   );

endinterface

// File: rtl/ahb_timeout_cnt.sv
// 8-bit ACCESS-cycle counter with terminal count at TIMEOUT-1.
// Clear has priority over enable.
module ahb_timeout_cnt #(
   parameter int TIMEOUT = 16
) (
   input  logic HCLK,
   input  logic HRESETN,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

   logic [7:0] cnt;

   // Count ACCESS cycles; restart on entry to a new access
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN)  cnt <= '0;
      else if (clr)  cnt <= '0;
      else if (en)   cnt <= cnt + 8'd1;
   end

   assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/ahb_slave_bridge.sv
// AHB-Lite subordinate to request/acknowledge register port bridge.
// Single word transfers, wait states until ack, ERROR on fault/timeout.
module ahb_slave_bridge
   import ahb_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic HCLK,
   input  logic HRESETN,
   ahb_slave_bridge_if.slave bus
);

   state_t state, state_nxt;

   logic              rdy_st;
   logic              take;
   logic              legal;
   logic              tc;
   logic              in_acc;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       rdata_q;
   logic              unused_bits;

   assign unused_bits = ^{bus.HBURST, bus.HADDR[31:ADDR_W]};

   assign rdy_st = (state == ST_IDLE) || (state == ST_DONE)
                || (state == ST_ERR2);
   assign take   = rdy_st && bus.HSEL && bus.HREADY && bus.HTRANS[1];
   assign legal  = is_legal(bus.HSIZE, bus.HADDR[1:0]);
   assign in_acc = (state == ST_ACCESS);

   ahb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .HCLK    (HCLK),
      .HRESETN (HRESETN),
      .clr     (take && legal),
      .en      (in_acc),
      .tc      (tc)
   );

   // State register
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state: ack beats timeout, new transfers only in ready states
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            if (take) state_nxt = legal ? ST_ACCESS : ST_ERR1;
            else      state_nxt = ST_IDLE;
         end
         ST_ACCESS: begin
            if (bus.usr_ack)
               state_nxt = bus.usr_err ? ST_ERR1 : ST_DONE;
            else if (tc)
               state_nxt = ST_ERR1;
         end
         ST_ERR1: state_nxt = ST_ERR2;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Bus-side outputs decoded from state
   always_comb begin
      bus.HREADYOUT = 1'b1;
      bus.HRESP     = HRESP_OKAY;
      bus.usr_req   = 1'b0;
      unique case (state)
         ST_ACCESS: begin
            bus.HREADYOUT = 1'b0;
            bus.usr_req   = 1'b1;
         end
         ST_ERR1: begin
            bus.HREADYOUT = 1'b0;
            bus.HRESP     = HRESP_ERROR;
         end
         ST_ERR2: bus.HRESP = HRESP_ERROR;
         default: ;
      endcase
   end

   // Address-phase capture, held through the access
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         addr_q <= '0;
         we_q   <= 1'b0;
      end else if (take) begin
         addr_q <= bus.HADDR[ADDR_W-1:0];
         we_q   <= bus.HWRITE;
      end
   end

   // Read data updates only on a successful read ack
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN)
         rdata_q <= '0;
      else if (in_acc && bus.usr_ack && !bus.usr_err && !we_q)
         rdata_q <= bus.usr_rdata;
   end

   assign bus.usr_addr  = addr_q;
   assign bus.usr_we    = we_q;
   assign bus.usr_wdata = bus.HWDATA;
   assign bus.HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_slave_bridge.sv
// Directed self-checking bench for ahb_slave_bridge (TIMEOUT=4).
// Inputs driven 2ns after the rising edge, outputs sampled 1ns later.
module tb_ahb_slave_bridge;
   import ahb_pkg::*;

   logic HCLK;
   logic HRESETN;
   int   ncmp;
   int   nfail;

   ahb_slave_bridge_if #(.ADDR_W(8)) bus ();

   ahb_slave_bridge #(
      .ADDR_W  (8),
      .TIMEOUT (4)
   ) dut (
      .HCLK    (HCLK),
      .HRESETN (HRESETN),
      .bus     (bus)
   );

   assign bus.HREADY = bus.HREADYOUT;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #2;
   endtask

   task automatic addr(input logic sel, input logic [1:0] tr,
                       input logic [31:0] a, input logic wr,
                       input logic [2:0] sz);
      bus.HSEL   = sel;
      bus.HTRANS = tr;
      bus.HADDR  = a;
      bus.HWRITE = wr;
      bus.HSIZE  = sz;
   endtask

   task automatic idle_bus();
      addr(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD);
   endtask

   task automatic chk_rsp(input string tag, input logic req,
                          input logic rdy, input logic rsp);
      #1;
      chk({tag, ".req"}, {31'd0, bus.usr_req}, {31'd0, req});
      chk({tag, ".rdy"}, {31'd0, bus.HREADYOUT}, {31'd0, rdy});
      chk({tag, ".rsp"}, {31'd0, bus.HRESP}, {31'd0, rsp});
   endtask

   initial begin
      ncmp  = 0;
      nfail = 0;
      HRESETN       = 1'b0;
      bus.HBURST    = 3'b000;
      bus.HWDATA    = 32'h5555_AAAA;
      bus.usr_ack   = 1'b0;
      bus.usr_err   = 1'b0;
      bus.usr_rdata = 32'h0;
      idle_bus();

      // Reset values
      #3;
      chk_rsp("rst", 1'b0, 1'b1, 1'b0);
      chk("rst.hrdata", bus.HRDATA, 32'h0);
      chk("rst.addr", {24'd0, bus.usr_addr}, 32'h0);
      chk("rst.we", {31'd0, bus.usr_we}, 32'h0);
      chk("rst.wdata", bus.usr_wdata, 32'h5555_AAAA);
      tick();
      HRESETN = 1'b1;
      tick();

      // Write, ack in third ACCESS cycle
      addr(1'b1, HTRANS_NONSEQ, 32'h0000_0010, 1'b1, HSIZE_WORD);
      chk_rsp("wr.c0", 1'b0, 1'b1, 1'b0);
      tick();
      idle_bus();
      bus.HWDATA = 32'hA5A5_1234;
      chk_rsp("wr.c1", 1'b1, 1'b0, 1'b0);
      chk("wr.addr", {24'd0, bus.usr_addr}, 32'h10);
      chk("wr.we", {31'd0, bus.usr_we}, 32'h1);
      chk("wr.wdata", bus.usr_wdata, 32'hA5A5_1234);
      tick();
      chk_rsp("wr.c2", 1'b1, 1'b0, 1'b0);
      tick();
      bus.usr_ack = 1'b1;
      chk_rsp("wr.c3", 1'b1, 1'b0, 1'b0);
      chk("wr.addr3", {24'd0, bus.usr_addr}, 32'h10);
      tick();
      bus.usr_ack = 1'b0;
      chk_rsp("wr.c4", 1'b0, 1'b1, 1'b0);
      chk("wr.hrdata", bus.HRDATA, 32'h0);
      tick();

      // Read, ack in first ACCESS cycle
      addr(1'b1, HTRANS_NONSEQ, 32'h0000_0004, 1'b0, HSIZE_WORD);
      tick();
      idle_bus();
      bus.usr_ack   = 1'b1;
      bus.usr_rdata = 32'hDEAD_BEEF;
      chk_rsp("rd.c1", 1'b1, 1'b0, 1'b0);
      chk("rd.addr", {24'd0, bus.usr_addr}, 32'h04);
      chk("rd.we", {31'd0, bus.usr_we}, 32'h0);
      tick();
      bus.usr_ack   = 1'b0;
      bus.usr_rdata = 32'h0;
      chk_rsp("rd.c2", 1'b0, 1'b1, 1'b0);
      chk("rd.hrdata", bus.HRDATA, 32'hDEAD_BEEF);
      tick();
      chk("rd.hold", bus.HRDATA, 32'hDEAD_BEEF);

      // Illegal: halfword size
      addr(1'b1, HTRANS_NONSEQ, 32'h0000_0008, 1'b0, 3'b001);
      tick();
      idle_bus();
      chk_rsp("hw.err1", 1'b0, 1'b0, 1'b1);
      tick();
      chk_rsp("hw.err2", 1'b0, 1'b1, 1'b1);
      tick();
      chk_rsp("hw.idle", 1'b0, 1'b1, 1'b0);

      // Illegal: unaligned word
      addr(1'b1, HTRANS_NONSEQ, 32'h0000_000A, 1'b1, HSIZE_WORD);
      tick();
      idle_bus();
      chk_rsp("ua.err1", 1'b0, 1'b0, 1'b1);
      tick();
      chk_rsp("ua.err2", 1'b0, 1'b1, 1'b1);
      tick();
      chk_rsp("ua.idle", 1'b0, 1'b1, 1'b0);

      // Timeout: 4 request cycles, then ERROR; late ack dropped
      addr(1'b1, HTRANS_NONSEQ, 32'h0000_000C, 1'b0, HSIZE_WORD);
      tick();
      idle_bus();
      chk_rsp("to.c1", 1'b1, 1'b0, 1'b0);
      tick();
      chk_rsp("to.c2", 1'b1, 1'b0, 1'b0);
      tick();
      chk_rsp("to.c3", 1'b1, 1'b0, 1'b0);
      tick();
      chk_rsp("to.c4", 1'b1, 1'b0, 1'b0);
      tick();
      chk_rsp("to.err1", 1'b0, 1'b0, 1'b1);
      tick();
      bus.usr_ack   = 1'b1;
      bus.usr_rdata = 32'h1234_5678;
      chk_rsp("to.err2", 1'b0, 1'b1, 1'b1);
      tick();
      bus.usr_ack = 1'b0;
      chk_rsp("to.late", 1'b0, 1'b1, 1'b0);
      chk("to.hrdata", bus.HRDATA, 32'hDEAD_BEEF);
      tick();

      // Back-to-back: write, then read accepted in DONE
      addr(1'b1, HTRANS_NONSEQ, 32'h0000_0020, 1'b1, HSIZE_WORD);
      tick();
      idle_bus();
      bus.HWDATA  = 32'h1111_2222;
      bus.usr_ack = 1'b1;
      chk_rsp("bb.w", 1'b1, 1'b0, 1'b0);
      chk("bb.wwe", {31'd0, bus.usr_we}, 32'h1);
      tick();
      bus.usr_ack = 1'b0;
      addr(1'b1, HTRANS_NONSEQ, 32'h0000_0024, 1'b0, HSIZE_WORD);
      chk_rsp("bb.done", 1'b0, 1'b1, 1'b0);
      tick();
      idle_bus();
      bus.usr_ack   = 1'b1;
      bus.usr_rdata = 32'hCAFE_F00D;
      chk_rsp("bb.r", 1'b1, 1'b0, 1'b0);
      chk("bb.rwe", {31'd0, bus.usr_we}, 32'h0);
      chk("bb.raddr", {24'd0, bus.usr_addr}, 32'h24);
      tick();
      bus.usr_ack = 1'b0;
      chk_rsp("bb.rdone", 1'b0, 1'b1, 1'b0);
      chk("bb.hrdata", bus.HRDATA, 32'hCAFE_F00D);
      tick();

      // Register-side error, then new transfer accepted in ERR2
      addr(1'b1, HTRANS_NONSEQ, 32'h0000_0030, 1'b0, HSIZE_WORD);
      tick();
      idle_bus();
      bus.usr_ack   = 1'b1;
      bus.usr_err   = 1'b1;
      bus.usr_rdata = 32'hBAD0_BAD0;
      tick();
      bus.usr_ack = 1'b0;
      bus.usr_err = 1'b0;
      chk_rsp("ue.err1", 1'b0, 1'b0, 1'b1);
      chk("ue.hrdata", bus.HRDATA, 32'hCAFE_F00D);
      tick();
      addr(1'b1, HTRANS_SEQ, 32'h0000_0040, 1'b1, HSIZE_WORD);
      chk_rsp("ue.err2", 1'b0, 1'b1, 1'b1);
      tick();
      idle_bus();
      chk_rsp("ue.next", 1'b1, 1'b0, 1'b0);
      chk("ue.addr", {24'd0, bus.usr_addr}, 32'h40);

      // Asynchronous reset mid-ACCESS
      HRESETN = 1'b0;
      chk_rsp("ar", 1'b0, 1'b1, 1'b0);
      chk("ar.hrdata", bus.HRDATA, 32'h0);
      chk("ar.addr", {24'd0, bus.usr_addr}, 32'h0);
      tick();
      HRESETN = 1'b1;
      tick();

      // IDLE and BUSY with HSEL=1, NONSEQ with HSEL=0
      addr(1'b1, HTRANS_IDLE, 32'h0000_0010, 1'b1, HSIZE_WORD);
      tick();
      chk_rsp("id", 1'b0, 1'b1, 1'b0);
      addr(1'b1, HTRANS_BUSY, 32'h0000_0010, 1'b1, HSIZE_WORD);
      tick();
      chk_rsp("busy", 1'b0, 1'b1, 1'b0);
      addr(1'b0, HTRANS_NONSEQ, 32'h0000_0010, 1'b1, HSIZE_WORD);
      tick();
      chk_rsp("nosel", 1'b0, 1'b1, 1'b0);
      idle_bus();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule
